// File: rtl/memgame_pkg.sv
// Shared definitions for the memory-match game: board geometry, field
// widths, controller state encoding and the card pairing rule. The
// upstream shuffler imports this package as well.
package memgame_pkg;

    localparam int NUM_CARDS_DEF = 20;
    localparam int NUM_PAIRS     = NUM_CARDS_DEF / 2;
    localparam int POS_W         = 5;
    localparam int ID_W          = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK1 = 3'd1,
        ST_PICK2 = 3'd2,
        ST_SHOW  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Two card IDs form a pair when they differ only in bit 0.
    function automatic logic is_pair(input logic [ID_W-1:0] a,
                                     input logic [ID_W-1:0] b);
        return (a >> 1) == (b >> 1);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Count-down timer for the face-up hold of a mismatched pair. A start
// loads HOLD_CYCLES; done is high during the last counted cycle, so the
// consumer acts on the edge that ends exactly HOLD_CYCLES cycles after
// the start edge. clear abandons a running count.
module hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic done
);

    localparam int              CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over start; an idle counter rests at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == ONE);

endmodule

// File: rtl/memory_match_ctrl.sv
// Memory-match game controller. Latches a shuffled board on load, accepts
// two selections per attempt, retires matching pairs and holds a
// mismatched pair face-up for HOLD_CYCLES before flipping it back.
module memory_match_ctrl
    import memgame_pkg::*;
#(
    parameter int NUM_CARDS   = NUM_CARDS_DEF,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CARDS-1:0][ID_W-1:0]  card_order,
    input  logic                            load,
    input  logic                            sel_valid,
    input  logic [POS_W-1:0]                sel_pos,
    output logic                            sel_ready,
    output logic [NUM_CARDS-1:0]            revealed,
    output logic [NUM_CARDS-1:0]            matched,
    output logic                            pair_ok,
    output logic                            pair_fail,
    output logic                            sel_err,
    output logic [7:0]                      move_count,
    output logic [3:0]                      pairs_found,
    output logic                            game_over
);

    localparam logic [POS_W:0] NUM_CARDS_W = (POS_W + 1)'(NUM_CARDS);
    localparam logic [3:0]     PAIRS_TOTAL = 4'(NUM_CARDS / 2);

    state_e                         state_q, state_d;
    logic [NUM_CARDS-1:0][ID_W-1:0] order_q, order_d;
    logic [POS_W-1:0]               pos1_q, pos1_d;
    logic [NUM_CARDS-1:0]           revealed_q, revealed_d;
    logic [NUM_CARDS-1:0]           matched_q, matched_d;
    logic [7:0]                     move_count_q, move_count_d;
    logic [3:0]                     pairs_found_q, pairs_found_d;
    logic                           pair_ok_q, pair_ok_d;
    logic                           pair_fail_q, pair_fail_d;
    logic                           sel_err_q, sel_err_d;
    logic                           sel_ready_q, sel_ready_d;
    logic                           game_over_q, game_over_d;

    logic sel_accept;
    logic pos_illegal;
    logic ids_pair;
    logic timer_start;
    logic timer_clear;
    logic timer_done;

    // A selection is only looked at while sel_ready is high (PICK1/PICK2).
    // Out-of-range positions short-circuit the matched lookup.
    assign sel_accept  = sel_valid && sel_ready_q;
    assign pos_illegal = ({1'b0, sel_pos} >= NUM_CARDS_W)
                      || matched_q[sel_pos]
                      || ((state_q == ST_PICK2) && (sel_pos == pos1_q));
    assign ids_pair    = is_pair(order_q[pos1_q], order_q[sel_pos]);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (timer_start),
        .clear (timer_clear),
        .done  (timer_done)
    );

    // Game FSM and datapath next-state; load overrides everything.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later statements see
        // earlier results; every register below is updated with '<=' instead.
        // NOTE: every _d starts from its _q (or 0 for pulses) so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_d       = state_q;
        order_d       = order_q;
        pos1_d        = pos1_q;
        revealed_d    = revealed_q;
        matched_d     = matched_q;
        move_count_d  = move_count_q;
        pairs_found_d = pairs_found_q;
        pair_ok_d     = 1'b0;
        pair_fail_d   = 1'b0;
        sel_err_d     = 1'b0;
        timer_start   = 1'b0;
        timer_clear   = 1'b0;

        if (load) begin
            order_d       = card_order;
            state_d       = ST_PICK1;
            revealed_d    = '0;
            matched_d     = '0;
            move_count_d  = '0;
            pairs_found_d = '0;
            timer_clear   = 1'b1;
        end else begin
            case (state_q)
                ST_PICK1: begin
                    if (sel_accept) begin
                        if (pos_illegal) begin
                            sel_err_d = 1'b1;
                        end else begin
                            pos1_d              = sel_pos;
                            revealed_d[sel_pos] = 1'b1;
                            state_d             = ST_PICK2;
                        end
                    end
                end

                ST_PICK2: begin
                    if (sel_accept) begin
                        if (pos_illegal) begin
                            sel_err_d = 1'b1;
                        end else begin
                            if (move_count_q != 8'hFF) begin
                                move_count_d = move_count_q + 8'd1;
                            end
                            if (ids_pair) begin
                                // The pair goes straight to matched; the
                                // second card is never shown as revealed.
                                revealed_d[pos1_q]  = 1'b0;
                                matched_d[pos1_q]   = 1'b1;
                                matched_d[sel_pos]  = 1'b1;
                                pairs_found_d       = pairs_found_q + 4'd1;
                                pair_ok_d           = 1'b1;
                                state_d = (pairs_found_q + 4'd1 == PAIRS_TOTAL)
                                          ? ST_DONE : ST_PICK1;
                            end else begin
                                revealed_d[sel_pos] = 1'b1;
                                pair_fail_d         = 1'b1;
                                timer_start         = 1'b1;
                                state_d             = ST_SHOW;
                            end
                        end
                    end
                end

                ST_SHOW: begin
                    // Only the mismatched pair is face-up here, so clearing
                    // the whole mask flips exactly those two cards back.
                    if (timer_done) begin
                        revealed_d = '0;
                        state_d    = ST_PICK1;
                    end
                end

                ST_IDLE, ST_DONE: begin
                    // Wait for load.
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        sel_ready_d = (state_d == ST_PICK1) || (state_d == ST_PICK2);
        game_over_d = (state_d == ST_DONE);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pos1_q        <= '0;
            revealed_q    <= '0;
            matched_q     <= '0;
            move_count_q  <= '0;
            pairs_found_q <= '0;
            pair_ok_q     <= 1'b0;
            pair_fail_q   <= 1'b0;
            sel_err_q     <= 1'b0;
            sel_ready_q   <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos1_q        <= pos1_d;
            revealed_q    <= revealed_d;
            matched_q     <= matched_d;
            move_count_q  <= move_count_d;
            pairs_found_q <= pairs_found_d;
            pair_ok_q     <= pair_ok_d;
            pair_fail_q   <= pair_fail_d;
            sel_err_q     <= sel_err_d;
            sel_ready_q   <= sel_ready_d;
            game_over_q   <= game_over_d;
        end
    end

    // Latched board order.
    // NOTE: this data store has no reset; it is only read after a load has
    // written it, so resetting it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        order_q <= order_d;
    end

    assign sel_ready   = sel_ready_q;
    assign revealed    = revealed_q;
    assign matched     = matched_q;
    assign pair_ok     = pair_ok_q;
    assign pair_fail   = pair_fail_q;
    assign sel_err     = sel_err_q;
    assign move_count  = move_count_q;
    assign pairs_found = pairs_found_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_memory_match_ctrl.sv
// Directed bench for memory_match_ctrl: a vector table for single-cycle
// behaviour followed by hand-written multi-cycle sequences.
module tb_memory_match_ctrl;
    import memgame_pkg::*;

    localparam int NC   = 20;
    localparam int HOLD = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NC-1:0][ID_W-1:0] card_order;
    logic                   load = 1'b0;
    logic                   sel_valid = 1'b0;
    logic [POS_W-1:0]       sel_pos = '0;
    logic                   sel_ready;
    logic [NC-1:0]          revealed;
    logic [NC-1:0]          matched;
    logic                   pair_ok;
    logic                   pair_fail;
    logic                   sel_err;
    logic [7:0]             move_count;
    logic [3:0]             pairs_found;
    logic                   game_over;

    int checks   = 0;
    int failures = 0;

    memory_match_ctrl #(
        .NUM_CARDS   (NC),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .card_order  (card_order),
        .load        (load),
        .sel_valid   (sel_valid),
        .sel_pos     (sel_pos),
        .sel_ready   (sel_ready),
        .revealed    (revealed),
        .matched     (matched),
        .pair_ok     (pair_ok),
        .pair_fail   (pair_fail),
        .sel_err     (sel_err),
        .move_count  (move_count),
        .pairs_found (pairs_found),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ld;
        logic          sv;
        logic [4:0]    pos;
        logic          rdy;
        logic [NC-1:0] rev;
        logic [NC-1:0] mat;
        logic          ok;
        logic          fl;
        logic          er;
        logic [7:0]    mc;
        logic [3:0]    pf;
        logic          go;
    } vec_t;

    function automatic vec_t mkv(input int ld, input int sv, input int pos,
                                 input int rdy, input int rev, input int mat,
                                 input int ok, input int fl, input int er,
                                 input int mc, input int pf, input int go);
        vec_t v;
        v.ld  = 1'(ld);
        v.sv  = 1'(sv);
        v.pos = 5'(pos);
        v.rdy = 1'(rdy);
        v.rev = NC'(rev);
        v.mat = NC'(mat);
        v.ok  = 1'(ok);
        v.fl  = 1'(fl);
        v.er  = 1'(er);
        v.mc  = 8'(mc);
        v.pf  = 4'(pf);
        v.go  = 1'(go);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int rdy, input int rev,
                             input int mat, input int ok, input int fl,
                             input int er, input int mc, input int pf,
                             input int go);
        check({tag, ".sel_ready"},   32'(sel_ready),   rdy);
        check({tag, ".revealed"},    32'(revealed),    rev);
        check({tag, ".matched"},     32'(matched),     mat);
        check({tag, ".pair_ok"},     32'(pair_ok),     ok);
        check({tag, ".pair_fail"},   32'(pair_fail),   fl);
        check({tag, ".sel_err"},     32'(sel_err),     er);
        check({tag, ".move_count"},  32'(move_count),  mc);
        check({tag, ".pairs_found"}, 32'(pairs_found), pf);
        check({tag, ".game_over"},   32'(game_over),   go);
    endtask

    // One clock of stimulus; outputs are sampled 1 ns after the edge.
    task automatic step(input int ld, input int sv, input int pos);
        @(negedge clk);
        load      = 1'(ld);
        sel_valid = 1'(sv);
        sel_pos   = 5'(pos);
        @(posedge clk);
        #1;
        load      = 1'b0;
        sel_valid = 1'b0;
    endtask

    task automatic set_identity();
        for (int i = 0; i < NC; i++) card_order[i] = 5'(i);
    endtask

    task automatic set_rotated();
        for (int i = 0; i < NC; i++) card_order[i] = 5'((i + 1) % NC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[18];

    initial begin
        // Identity board, HOLD=4: pair, illegal picks, mismatch hold, pair.
        vecs[0]  = mkv(1, 0,  0, 1, 'h00000, 'h00, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(0, 1,  0, 1, 'h00001, 'h00, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 1,  1, 1, 'h00000, 'h03, 1, 0, 0, 1, 1, 0);
        vecs[3]  = mkv(0, 0,  0, 1, 'h00000, 'h03, 0, 0, 0, 1, 1, 0);
        vecs[4]  = mkv(0, 1,  5, 1, 'h00020, 'h03, 0, 0, 0, 1, 1, 0);
        vecs[5]  = mkv(0, 1,  5, 1, 'h00020, 'h03, 0, 0, 1, 1, 1, 0);
        vecs[6]  = mkv(0, 1, 25, 1, 'h00020, 'h03, 0, 0, 1, 1, 1, 0);
        vecs[7]  = mkv(0, 1,  0, 1, 'h00020, 'h03, 0, 0, 1, 1, 1, 0);
        vecs[8]  = mkv(0, 1,  7, 0, 'h000A0, 'h03, 0, 1, 0, 2, 1, 0);
        vecs[9]  = mkv(0, 0,  0, 0, 'h000A0, 'h03, 0, 0, 0, 2, 1, 0);
        vecs[10] = mkv(0, 1,  9, 0, 'h000A0, 'h03, 0, 0, 0, 2, 1, 0);
        vecs[11] = mkv(0, 0,  0, 0, 'h000A0, 'h03, 0, 0, 0, 2, 1, 0);
        vecs[12] = mkv(0, 0,  0, 1, 'h00000, 'h03, 0, 0, 0, 2, 1, 0);
        vecs[13] = mkv(0, 1,  4, 1, 'h00010, 'h03, 0, 0, 0, 2, 1, 0);
        vecs[14] = mkv(0, 1,  5, 1, 'h00000, 'h33, 1, 0, 0, 3, 2, 0);
        vecs[15] = mkv(0, 1,  0, 1, 'h00000, 'h33, 0, 0, 1, 3, 2, 0);
        vecs[16] = mkv(0, 1, 19, 1, 'h80000, 'h33, 0, 0, 0, 3, 2, 0);
        vecs[17] = mkv(0, 1, 20, 1, 'h80000, 'h33, 0, 0, 1, 3, 2, 0);

        set_identity();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 3);
        check_all("idle_ignores_sel", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Table-driven vectors.
        for (int i = 0; i < 18; i++) begin
            step(int'(vecs[i].ld), int'(vecs[i].sv), int'(vecs[i].pos));
            check_all($sformatf("vec%0d", i), int'(vecs[i].rdy),
                      int'(vecs[i].rev), int'(vecs[i].mat), int'(vecs[i].ok),
                      int'(vecs[i].fl), int'(vecs[i].er), int'(vecs[i].mc),
                      int'(vecs[i].pf), int'(vecs[i].go));
        end

        // Full game with identity order.
        step(1, 0, 0);
        for (int p = 0; p < 10; p++) begin
            step(0, 1, 2 * p);
            check($sformatf("game.p%0d.rev", p), 32'(revealed), 1 << (2 * p));
            step(0, 1, 2 * p + 1);
            check($sformatf("game.p%0d.ok", p), 32'(pair_ok), 1);
            check($sformatf("game.p%0d.mat", p), 32'(matched),
                  (1 << (2 * p + 2)) - 1);
            check($sformatf("game.p%0d.pf", p), 32'(pairs_found), p + 1);
        end
        check_all("game.end", 0, 0, 'hFFFFF, 1, 0, 0, 10, 10, 1);
        step(0, 1, 3);
        check_all("game.done_hold", 0, 0, 'hFFFFF, 0, 0, 0, 10, 10, 1);

        // Latched order: change card_order after load; latched IDs rule.
        set_rotated();
        step(1, 0, 0);
        check_all("rot.load", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        set_identity();
        step(0, 1, 1);
        step(0, 1, 2);
        check_all("rot.pair12", 1, 0, 'h6, 1, 0, 0, 1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 3);
        check_all("rot.miss03", 0, 'h9, 'h6, 0, 1, 0, 2, 1, 0);

        // Load during SHOW with a simultaneous selection.
        step(1, 1, 4);
        check_all("abort.load", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0);
            check($sformatf("abort.quiet%0d.rev", k), 32'(revealed), 0);
            check($sformatf("abort.quiet%0d.rdy", k), 32'(sel_ready), 1);
        end
        step(0, 1, 0);
        step(0, 1, 1);
        check_all("abort.newpair", 1, 0, 'h3, 1, 0, 0, 1, 1, 0);

        // Mismatch hold length and move_count saturation.
        step(1, 0, 0);
        for (int k = 0; k < 256; k++) begin
            step(0, 1, 0);
            step(0, 1, 2);
            if (k == 0) begin
                check_all("hold.fail", 0, 'h5, 0, 0, 1, 0, 1, 0, 0);
                for (int c = 1; c < HOLD; c++) begin
                    step(0, 0, 0);
                    check($sformatf("hold.c%0d.rev", c), 32'(revealed), 'h5);
                end
                step(0, 0, 0);
                check_all("hold.back", 1, 0, 0, 0, 0, 0, 1, 0, 0);
            end else begin
                repeat (HOLD) step(0, 0, 0);
            end
            if (k == 254) check("sat.at255", 32'(move_count), 255);
        end
        check_all("sat.end", 1, 0, 0, 0, 0, 0, 255, 0, 0);

        // Asynchronous reset in the middle of PICK2.
        step(1, 0, 0);
        step(0, 1, 0);
        check("rst.pre.rev", 32'(revealed), 1);
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        sel_valid = 1'b1;
        sel_pos   = 5'd1;
        #1;
        check_all("rst.async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst.release", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sel_valid = 1'b0;
        step(1, 0, 0);
        check_all("rst.reload", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_match_ctrl.md
MEMORY_MATCH_CTRL -- requirements
Module: memory_match_ctrl

Interface
REQ-001 Parameter NUM_CARDS, default 20: number of card positions; always even.
REQ-002 Parameter HOLD_CYCLES, default 50_000_000: cycles a mismatched pair stays face-up; minimum 1.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 card_order  in  NUM_CARDS x 5  shuffled card IDs 0..NUM_CARDS-1 from the upstream shuffler, indexed by board position.
REQ-006 load  in  1  one-cycle pulse: capture card_order and start a new game.
REQ-007 sel_valid  in  1  player selection strobe.
REQ-008 sel_pos  in  5  board position selected.
REQ-009 sel_ready  out  1  high when a selection will be accepted.
REQ-010 revealed  out  NUM_CARDS  currently face-up, unmatched positions.
REQ-011 matched  out  NUM_CARDS  positions permanently removed as found pairs.
REQ-012 pair_ok / pair_fail / sel_err  out  1 each  one-cycle event pulses.
REQ-013 move_count  out  8  completed pair attempts, saturating at 255.
REQ-014 pairs_found  out  4  pairs matched this game.
REQ-015 game_over  out  1  high once all pairs are matched.

Function
REQ-016 Pair rule: IDs a and b match iff a>>1 == b>>1, giving NUM_CARDS/2 pairs.
REQ-017 States: IDLE, PICK1, PICK2, SHOW, DONE.
REQ-018 IDLE: sel_ready=0; load latches card_order into an internal register, clears revealed, matched and counters, then enters PICK1 next cycle.
REQ-019 Selection accept: sel_valid & sel_ready in PICK1 or PICK2.
REQ-020 Illegal selection: sel_pos>=NUM_CARDS, matched[sel_pos]=1, or equal to the first pick; it is ignored, sel_err pulses the next cycle, and state is unchanged.
REQ-021 PICK1 accept: store pos1, set revealed[pos1], go to PICK2.
REQ-022 PICK2 accept: set revealed[pos2]; compare the latched IDs on the same edge; move_count increments.
REQ-023 On match: pair_ok pulses the next cycle; both bits move from revealed to matched; pairs_found increments; go to DONE if pairs_found reaches NUM_CARDS/2, else PICK1.
REQ-024 On mismatch: pair_fail pulses the next cycle; go to SHOW; sel_ready=0.
REQ-025 SHOW: after exactly HOLD_CYCLES cycles, clear both revealed bits and return to PICK1.
REQ-026 DONE: game_over=1 and sel_ready=0; hold until load.
REQ-027 load in any state aborts the current game and behaves as in IDLE; load takes priority over a simultaneous selection.
REQ-028 sel_ready = 1 only in PICK1 and PICK2; it is a registered output.
REQ-029 The latched order is never re-read from card_order after load; upstream changes mid-game have no effect.

Reset
REQ-030 rst_n low: state IDLE; revealed, matched, move_count and pairs_found = 0; all pulses and game_over = 0; the hold timer is cleared immediately.
REQ-031 Reset during SHOW or PICK2 discards the pending pair with no pulse emitted.

Structure
REQ-032 Package memgame_pkg holds NUM_CARDS_DEF, NUM_PAIRS, POS_W=5, ID_W=5 and the state enum type; the upstream shuffler also uses this package.
REQ-033 One sub-module, hold_timer: a load/start, count-down to done pulse timer parameterised by HOLD_CYCLES, used for SHOW.

Verification
REQ-034 Identity order 0..19 loaded, picks 0 then 1 -> pair_ok at the next cycle, matched=0x00003, pairs_found=1, move_count=1.
REQ-035 Identity order, picks 0 then 2, HOLD_CYCLES=4 -> pair_fail; revealed=0x00005 for 4 cycles, then 0; state PICK1.
REQ-036 Pick 5, pick 5 again, pick 25, pick an already matched position -> sel_err each time, with no state or counter change.
REQ-037 Identity order, picks (0,1),(2,3)...(18,19) -> game_over=1 after the 10th pair_ok, pairs_found=10, move_count=10, sel_ready=0.
REQ-038 load asserted during SHOW with the same-cycle sel_valid -> all masks and counters cleared, PICK1 entered, selection ignored.
REQ-039 rst_n pulsed low mid-PICK2 -> all outputs zero asynchronously and state IDLE after release.
